// File: rtl/mem_port_seq.sv
// Load/dump sequencer for a single-port synchronous memory with a 1-cycle registered read.
// Streams host words into a memory region (load) or reads a region back out as a stream (dump).
module mem_port_seq #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_base_i,
    input  logic [ADDR_W:0]   cmd_cnt_i,

    input  logic              din_valid_i,
    output logic              din_ready_o,
    input  logic [DATA_W-1:0] din_data_i,

    output logic              dout_valid_o,
    input  logic              dout_ready_i,
    output logic [DATA_W-1:0] dout_data_o,

    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              busy_o,
    output logic              done_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RD_ADDR,
        RD_WAIT,
        RD_OUT,
        DONE
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W:0]   cnt_reg;

    logic [ADDR_W:0]   cnt_clamped;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W:0]   cnt_dec;
    logic              last_word;
    logic              cmd_fire;
    logic              din_fire;
    logic              dout_fire;

    // Counts above DEPTH would revisit addresses, so they are limited to one full pass.
    assign cnt_clamped = (cmd_cnt_i > DEPTH_CNT) ? DEPTH_CNT : cmd_cnt_i;
    assign addr_inc    = addr_reg + ADDR_ONE;
    assign cnt_dec     = cnt_reg - CNT_ONE;
    assign last_word   = (cnt_reg == CNT_ONE);
    assign cmd_fire    = cmd_valid_i & cmd_ready_o;
    assign din_fire    = din_valid_i & din_ready_o;
    assign dout_fire   = dout_valid_o & dout_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            cnt_reg      <= '0;
            cmd_ready_o  <= 1'b1;
            din_ready_o  <= 1'b0;
            dout_valid_o <= 1'b0;
            dout_data_o  <= '0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            // Write strobe and completion pulse only live for the cycle after their cause.
            mem_we_o <= 1'b0;
            done_o   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (cmd_fire) begin
                        addr_reg    <= cmd_base_i;
                        cnt_reg     <= cnt_clamped;
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        if (cnt_clamped == '0) begin
                            state_reg <= DONE;
                            done_o    <= 1'b1;
                        end else if (cmd_op_i) begin
                            state_reg   <= LOAD;
                            din_ready_o <= 1'b1;
                        end else begin
                            state_reg  <= RD_ADDR;
                            mem_addr_o <= cmd_base_i;
                        end
                    end
                end

                LOAD: begin
                    if (din_fire) begin
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= addr_reg;
                        mem_wdata_o <= din_data_i;
                        addr_reg    <= addr_inc;
                        cnt_reg     <= cnt_dec;
                        if (last_word) begin
                            state_reg   <= DONE;
                            din_ready_o <= 1'b0;
                            done_o      <= 1'b1;
                        end
                    end
                end

                RD_ADDR: begin
                    state_reg <= RD_WAIT;
                end

                // Memory returns the word addressed during RD_ADDR in this cycle.
                RD_WAIT: begin
                    dout_data_o  <= mem_rdata_i;
                    dout_valid_o <= 1'b1;
                    state_reg    <= RD_OUT;
                end

                RD_OUT: begin
                    if (dout_fire) begin
                        dout_valid_o <= 1'b0;
                        cnt_reg      <= cnt_dec;
                        if (last_word) begin
                            state_reg <= DONE;
                            done_o    <= 1'b1;
                        end else begin
                            addr_reg   <= addr_inc;
                            mem_addr_o <= addr_inc;
                            state_reg  <= RD_ADDR;
                        end
                    end
                end

                DONE: begin
                    state_reg   <= IDLE;
                    busy_o      <= 1'b0;
                    cmd_ready_o <= 1'b1;
                end

                default: begin
                    state_reg    <= IDLE;
                    busy_o       <= 1'b0;
                    cmd_ready_o  <= 1'b1;
                    din_ready_o  <= 1'b0;
                    dout_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
